// File: rtl/twobit_sum_accumulator.sv
// Accumulates NUM_SAMPLES 3-bit results of the 2-bit adder and offers the total
// on a valid/ack handshake. Define ACCUM_SATURATE_EN to clamp instead of wrapping.
module twobit_sum_accumulator #(
  parameter int ACC_W       = 6,
  parameter int NUM_SAMPLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             s0,
  input  logic             s1,
  input  logic             carry,
  output logic             in_ready,
  output logic             busy,
  output logic [7:0]       sample_cnt,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t state;
  state_t next_state;

  logic           accept;
  logic           last_sample;
  logic           clear_run;
  logic [ACC_W:0] sum;

  assign accept      = in_valid && in_ready;
  assign last_sample = (sample_cnt == 8'(NUM_SAMPLES - 1));
  // A new run starts from IDLE, or straight out of DONE when the result is taken.
  assign clear_run   = start && ((state == IDLE) || ((state == DONE) && out_ack));
  assign sum         = {1'b0, acc_out} + {{(ACC_W-2){1'b0}}, carry, s1, s0};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = start ? ACCUM : IDLE;
      ACCUM:   next_state = (accept && last_sample) ? DONE : ACCUM;
      DONE: begin
        if (out_ack) next_state = start ? ACCUM : IDLE;
        else         next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    busy      = (state == ACCUM);
    out_valid = (state == DONE);
  end

  // The carry-out of the widened add is the overflow event for this sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out    <= '0;
      sample_cnt <= '0;
      overflow   <= 1'b0;
    end else if (clear_run) begin
      acc_out    <= '0;
      sample_cnt <= '0;
      overflow   <= 1'b0;
    end else if (accept) begin
      sample_cnt <= sample_cnt + 8'd1;
      overflow   <= overflow | sum[ACC_W];
`ifdef ACCUM_SATURATE_EN
      acc_out    <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      acc_out    <= sum[ACC_W-1:0];
`endif
    end
  end

endmodule

// File: tb/tb_twobit_sum_accumulator.sv
// Bench for twobit_sum_accumulator: instance 0 runs 4-sample runs, instance 1 the
// default 16-sample runs; both use ACC_W=6 and are checked against a sum-based model.
module tb_twobit_sum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s[2], start_s[2], in_valid_s[2], s0_s[2], s1_s[2], carry_s[2], out_ack_s[2];
  logic       in_ready_s[2], busy_s[2], overflow_s[2], out_valid_s[2];
  logic [7:0] cnt_s[2];
  logic [5:0] acc_s[2];

  twobit_sum_accumulator #(.ACC_W(6), .NUM_SAMPLES(4)) dut4 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .s0(s0_s[0]), .s1(s1_s[0]), .carry(carry_s[0]), .in_ready(in_ready_s[0]),
    .busy(busy_s[0]), .sample_cnt(cnt_s[0]), .acc_out(acc_s[0]),
    .overflow(overflow_s[0]), .out_valid(out_valid_s[0]), .out_ack(out_ack_s[0])
  );

  twobit_sum_accumulator #(.ACC_W(6), .NUM_SAMPLES(16)) dut16 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .s0(s0_s[1]), .s1(s1_s[1]), .carry(carry_s[1]), .in_ready(in_ready_s[1]),
    .busy(busy_s[1]), .sample_cnt(cnt_s[1]), .acc_out(acc_s[1]),
    .overflow(overflow_s[1]), .out_valid(out_valid_s[1]), .out_ack(out_ack_s[1])
  );

  int vec_count   = 0;
  int miscompares = 0;

  // Model: 0 = idle, 1 = collecting, 2 = result held; total is the exact integer sum.
  int m_phase[2];
  int m_total[2];
  int m_cnt[2];

  function automatic int n_samples(input int sel);
    return (sel == 0) ? 4 : 16;
  endfunction

  function automatic int model_acc(input int total);
`ifdef ACCUM_SATURATE_EN
    return (total > 63) ? 63 : total;
`else
    return total % 64;
`endif
  endfunction

  task automatic model_update(input int sel);
    int v;
    v = 4 * int'(carry_s[sel]) + 2 * int'(s1_s[sel]) + int'(s0_s[sel]);
    if (rst_s[sel]) begin
      m_phase[sel] = 0; m_total[sel] = 0; m_cnt[sel] = 0;
    end else if (m_phase[sel] == 0) begin
      if (start_s[sel]) begin
        m_phase[sel] = 1; m_total[sel] = 0; m_cnt[sel] = 0;
      end
    end else if (m_phase[sel] == 1) begin
      if (in_valid_s[sel]) begin
        m_total[sel] += v;
        m_cnt[sel]   += 1;
        if (m_cnt[sel] == n_samples(sel)) m_phase[sel] = 2;
      end
    end else if (out_ack_s[sel]) begin
      if (start_s[sel]) begin
        m_phase[sel] = 1; m_total[sel] = 0; m_cnt[sel] = 0;
      end else begin
        m_phase[sel] = 0;
      end
    end
  endtask

  task automatic compare(input string name, input int sel, input int got, input int want);
    vec_count++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s (dut%0d): got %0d, expected %0d", name, sel, got, want);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic rst, input logic start,
                               input logic in_valid, input int v, input logic out_ack);
    logic [2:0] bits;
    bits            = 3'(v);
    rst_s[sel]      = rst;
    start_s[sel]    = start;
    in_valid_s[sel] = in_valid;
    carry_s[sel]    = bits[2];
    s1_s[sel]       = bits[1];
    s0_s[sel]       = bits[0];
    out_ack_s[sel]  = out_ack;
    @(posedge clk);
    model_update(sel);
    #1;
  endtask

  task automatic checkOutput(input int sel, input string name, input logic e_ready,
                             input logic e_valid, input int e_cnt, input int e_acc,
                             input logic e_ov);
    compare({name, ".in_ready"},   sel, int'(in_ready_s[sel]),  int'(e_ready));
    compare({name, ".busy"},       sel, int'(busy_s[sel]),      int'(e_ready));
    compare({name, ".out_valid"},  sel, int'(out_valid_s[sel]), int'(e_valid));
    compare({name, ".sample_cnt"}, sel, int'(cnt_s[sel]),       e_cnt);
    compare({name, ".acc_out"},    sel, int'(acc_s[sel]),       e_acc);
    compare({name, ".overflow"},   sel, int'(overflow_s[sel]),  int'(e_ov));
  endtask

  task automatic check_model(input int sel, input string name);
    checkOutput(sel, name, m_phase[sel] == 1, m_phase[sel] == 2, m_cnt[sel],
                model_acc(m_total[sel]), m_total[sel] > 63);
  endtask

  typedef struct {
    logic rst, start, in_valid;
    int   v;
    logic out_ack;
    logic e_ready, e_valid;
    int   e_cnt, e_acc;
    logic e_ov;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int exp_ovf_acc;
    for (int s = 0; s < 2; s++) begin
      rst_s[s] = 1'b0; start_s[s] = 1'b0; in_valid_s[s] = 1'b0; s0_s[s] = 1'b0;
      s1_s[s] = 1'b0; carry_s[s] = 1'b0; out_ack_s[s] = 1'b0;
      m_phase[s] = 0; m_total[s] = 0; m_cnt[s] = 0;
    end

    //            rst  start iv   v  ack   rdy  vld  cnt acc ov
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0,  0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0,  0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1,  3, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 6, 1'b0, 1'b1, 1'b0, 2,  9, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 3, 10, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b0, 3, 10, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 4, 10, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 4, 10, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b1, 4, 10, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 4, 10, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b0, 4, 10, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0,  0, 1'b0};

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, tbl[i].rst, tbl[i].start, tbl[i].in_valid, tbl[i].v, tbl[i].out_ack);
      checkOutput(0, $sformatf("table[%0d]", i), tbl[i].e_ready, tbl[i].e_valid,
                  tbl[i].e_cnt, tbl[i].e_acc, tbl[i].e_ov);
    end

    // Reset in the middle of a 16-sample run discards the partial sum.
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b1, 5, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b1, 6, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b1, 4, 1'b0);
    checkOutput(1, "midrun_before_rst", 1'b1, 1'b0, 3, 15, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 6, 1'b0);
    checkOutput(1, "midrun_after_rst", 1'b0, 1'b0, 0, 0, 1'b0);

    // Backpressure: two idle cycles after every sample.
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    begin
      int vals[4] = '{3, 6, 1, 0};
      for (int k = 0; k < 4; k++) begin
        applyStimulus(0, 1'b0, 1'b0, 1'b1, vals[k], 1'b0);
        if (k < 3) begin
          applyStimulus(0, 1'b0, 1'b0, 1'b0, 7, 1'b0);
          applyStimulus(0, 1'b0, 1'b0, 1'b0, 7, 1'b0);
          checkOutput(0, $sformatf("gap_%0d", k), 1'b1, 1'b0, k + 1,
                      (k == 0) ? 3 : (k == 1) ? 9 : 10, 1'b0);
        end
      end
    end
    checkOutput(0, "gap_done", 1'b0, 1'b1, 4, 10, 1'b0);

    // Back-to-back: ack with start goes straight into a fresh run.
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    checkOutput(0, "b2b_restart", 1'b1, 1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    checkOutput(0, "b2b_second_run", 1'b0, 1'b1, 4, 4, 1'b0);

    // Overflow: 16 samples of 6 sum to 96.
`ifdef ACCUM_SATURATE_EN
    exp_ovf_acc = 63;
`else
    exp_ovf_acc = 32;
`endif
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    for (int k = 0; k < 16; k++) applyStimulus(1, 1'b0, 1'b0, 1'b1, 6, 1'b0);
    checkOutput(1, "overflow_done", 1'b0, 1'b1, 16, exp_ovf_acc, 1'b1);

    // Handshake hold: start is ignored in DONE until out_ack arrives.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 1'b0, k[0] == 1'b0, 1'b1, 2, 1'b0);
      checkOutput(1, $sformatf("hold_%0d", k), 1'b0, 1'b1, 16, exp_ovf_acc, 1'b1);
    end
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    checkOutput(1, "hold_ack", 1'b0, 1'b0, 16, exp_ovf_acc, 1'b1);

    // Randomized traffic on both instances against the sum model.
    for (int s = 0; s < 2; s++) begin
      applyStimulus(s, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      for (int n = 0; n < 300; n++) begin
        applyStimulus(s, $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) != 0, int'($urandom_range(0, 6)),
                      $urandom_range(0, 2) == 0);
        check_model(s, $sformatf("rand%0d_%0d", s, n));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
